// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and the 32 x 32-bit architectural register file.
// This block selects the write-back value (ALU result or load data) and commits it
// to the register file. It serves the two ID-stage read ports and counts retired
// register writes.
// Optional feature macro: WB_BYPASS_EN. When it is defined, a write presented in a
// cycle is forwarded to a matching read port in that same cycle.
// x0 is never written and always reads as zero.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              RegWrite_i,
   input  logic              MemtoReg_i,
   input  logic [DATA_W-1:0] ALUResult_i,
   input  logic [DATA_W-1:0] Memdata_i,
   input  logic [4:0]        RDaddr_i,
   input  logic [4:0]        RS1addr_i,
   input  logic [4:0]        RS2addr_i,
   output logic [DATA_W-1:0] RS1data_o,
   output logic [DATA_W-1:0] RS2data_o,
   output logic [DATA_W-1:0] WBdata_o,
   output logic [31:0]       WBcount_o
);

   // Entry 0 exists only to keep indexing simple. It is held at zero and is never read.
   logic [DATA_W-1:0] regs_q [0:NREG-1];
   logic [31:0]       wbcount_q;
   logic [31:0]       wbcount_d;
   logic [DATA_W-1:0] wb_data_s;
   logic              wr_en_s;
   logic [DATA_W-1:0] rs1_data_s;
   logic [DATA_W-1:0] rs2_data_s;
`ifdef WB_BYPASS_EN
   logic              byp_en_s;
`endif

   // Write-back mux and commit qualifier; the mux output is valid whether or not RegWrite_i is set
   always_comb begin
      wb_data_s = ALUResult_i;
      if (MemtoReg_i) begin
         wb_data_s = Memdata_i;
      end else begin
         wb_data_s = ALUResult_i;
      end
      wr_en_s = RegWrite_i && (RDaddr_i != 5'd0);
   end

`ifdef WB_BYPASS_EN
   // Forwarding is suppressed during reset, because the write in that cycle is dropped
   always_comb begin
      byp_en_s = rst_n_i && wr_en_s;
   end
`endif

   // Read port 1: x0 reads zero, then the optional same-cycle bypass, then the array
   always_comb begin
      rs1_data_s = {DATA_W{1'b0}};
      if (RS1addr_i == 5'd0) begin
         rs1_data_s = {DATA_W{1'b0}};
`ifdef WB_BYPASS_EN
      end else if (byp_en_s && (RS1addr_i == RDaddr_i)) begin
         rs1_data_s = wb_data_s;
`endif
      end else begin
         rs1_data_s = regs_q[RS1addr_i];
      end
   end

   // Read port 2: this port decides its bypass independently of port 1
   always_comb begin
      rs2_data_s = {DATA_W{1'b0}};
      if (RS2addr_i == 5'd0) begin
         rs2_data_s = {DATA_W{1'b0}};
`ifdef WB_BYPASS_EN
      end else if (byp_en_s && (RS2addr_i == RDaddr_i)) begin
         rs2_data_s = wb_data_s;
`endif
      end else begin
         rs2_data_s = regs_q[RS2addr_i];
      end
   end

   // Retired-write counter next state: every RegWrite_i counts, x0 included, and the count wraps silently
   always_comb begin
      wbcount_d = wbcount_q;
      if (RegWrite_i) begin
         wbcount_d = wbcount_q + 32'd1;
      end else begin
         wbcount_d = wbcount_q;
      end
   end

   // Register array: clear everything on reset, otherwise commit the write-back value to a non-zero destination
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_en_s) begin
         regs_q[RDaddr_i] <= wb_data_s;
      end
   end

   // Counter register: reset to zero; a count presented in the reset cycle is dropped
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wbcount_q <= 32'd0;
      end else begin
         wbcount_q <= wbcount_d;
      end
   end

   assign RS1data_o = rs1_data_s;
   assign RS2data_o = rs2_data_s;
   assign WBdata_o  = wb_data_s;
   assign WBcount_o = wbcount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile.
// It runs three parts in order:
//   1. A directed table of per-cycle vectors.
//   2. A counter-wrap sequence that uses a back-door preload of the counter.
//   3. Randomized cycles checked against an array-based reference model.
// The bench builds with or without WB_BYPASS_EN.
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        we;
   logic        mtr;
   logic [31:0] alu;
   logic [31:0] memd;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wb_data;
   logic [31:0] wb_count;

   int checks = 0;
   int errors = 0;

   // Reference model: architectural register contents and the retired-write count
   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   typedef struct {
      logic        rst;
      logic        we;
      logic        mtr;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic [31:0] e_wb;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [14];

   wb_regfile dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .RegWrite_i  (we),
      .MemtoReg_i  (mtr),
      .ALUResult_i (alu),
      .Memdata_i   (memd),
      .RDaddr_i    (rd),
      .RS1addr_i   (rs1),
      .RS2addr_i   (rs2),
      .RS1data_o   (rs1_data),
      .RS2data_o   (rs2_data),
      .WBdata_o    (wb_data),
      .WBcount_o   (wb_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so that the run always ends on its own
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(input logic r, input logic w, input logic m,
                               input logic [31:0] a, input logic [31:0] md,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [31:0] er1, input logic [31:0] er2,
                               input logic [31:0] ewb, input logic [31:0] ecnt);
      vec_t v;
      v.rst = r; v.we = w; v.mtr = m; v.alu = a; v.mem = md; v.rd = d;
      v.rs1 = s1; v.rs2 = s2; v.e_rs1 = er1; v.e_rs2 = er2; v.e_wb = ewb; v.e_cnt = ecnt;
      return v;
   endfunction

   // Model of a read port, taken directly from the read and bypass rules
   function automatic logic [31:0] m_read(input logic [4:0] a, input logic r, input logic w,
                                          input logic [4:0] d, input logic [31:0] wbv);
      if (a == 5'd0) return 32'd0;
      if (BP && r && w && (d != 5'd0) && (d == a)) return wbv;
      return m_regs[a];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
   endtask

   // One clock cycle. Drive the inputs after the falling edge and check the outputs
   // before the rising edge. The model advances as the rising edge would.
   task automatic cycle(input vec_t v, input string tag);
      logic [31:0] wbv;
      rst_n = v.rst; we = v.we; mtr = v.mtr; alu = v.alu; memd = v.mem;
      rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
      #2;
      chk({tag, " rs1"}, rs1_data, v.e_rs1);
      chk({tag, " rs2"}, rs2_data, v.e_rs2);
      chk({tag, " wb"},  wb_data,  v.e_wb);
      chk({tag, " cnt"}, wb_count, v.e_cnt);
      @(posedge clk);
      wbv = v.mtr ? v.mem : v.alu;
      if (!v.rst) begin
         model_reset();
      end else if (v.we) begin
         m_cnt = m_cnt + 32'd1;
         if (v.rd != 5'd0) m_regs[v.rd] = wbv;
      end
      @(negedge clk);
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0; we = 1'b0; mtr = 1'b0; alu = 32'd0; memd = 32'd0;
      rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      model_reset();
      @(posedge clk);
      @(negedge clk);

      // Directed table. Rows 0-2: reset, 3-6: mux/commit, 7-8: x0, 9-10: bypass, 11-13: reset mid-stream
      tbl[0]  = mk(1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0, 32'h11, 32'd0);
      tbl[1]  = mk(1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0, 32'h11, 32'd0);
      tbl[2]  = mk(1'b1, 1'b0, 1'b0, 32'h11, 32'h0, 5'd5, 5'd5, 5'd5, 32'h0, 32'h0, 32'h11, 32'd0);
      tbl[3]  = mk(1'b1, 1'b1, 1'b0, 32'h1234, 32'hDEAD, 5'd3, 5'd3, 5'd0,
                   BP ? 32'h1234 : 32'h0, 32'h0, 32'h1234, 32'd0);
      tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'h1234, 32'hDEAD, 5'd3, 5'd3, 5'd3,
                   32'h1234, 32'h1234, 32'h1234, 32'd1);
      tbl[5]  = mk(1'b1, 1'b1, 1'b1, 32'h1234, 32'hDEAD, 5'd3, 5'd3, 5'd4,
                   BP ? 32'hDEAD : 32'h1234, 32'h0, 32'hDEAD, 32'd1);
      tbl[6]  = mk(1'b1, 1'b0, 1'b1, 32'h1234, 32'hDEAD, 5'd3, 5'd3, 5'd4,
                   32'hDEAD, 32'h0, 32'hDEAD, 32'd2);
      tbl[7]  = mk(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'hFFFFFFFF, 32'd2);
      tbl[8]  = mk(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd3,
                   32'h0, 32'hDEAD, 32'hFFFFFFFF, 32'd3);
      tbl[9]  = mk(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7, 5'd7,
                   BP ? 32'hA5A5A5A5 : 32'h0, BP ? 32'hA5A5A5A5 : 32'h0, 32'hA5A5A5A5, 32'd3);
      tbl[10] = mk(1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7, 5'd7,
                   32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd4);
      tbl[11] = mk(1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5'd9, 5'd9, 5'd7,
                   32'h0, 32'hA5A5A5A5, 32'h55, 32'd4);
      tbl[12] = mk(1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 5'd9, 5'd9, 5'd7,
                   BP ? 32'h66 : 32'h0, 32'h0, 32'h66, 32'd0);
      tbl[13] = mk(1'b1, 1'b0, 1'b0, 32'h66, 32'h0, 5'd9, 5'd9, 5'd9,
                   32'h66, 32'h66, 32'h66, 32'd1);

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i], $sformatf("vec%0d", i));
      end

      // Counter wrap: preload the counter through the back door, then retire one write to x0
      force dut.wbcount_q = 32'hFFFFFFFF;
      #1;
      release dut.wbcount_q;
      m_cnt = 32'hFFFFFFFF;
      v = mk(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h66, 32'h0, 32'hFFFFFFFF);
      cycle(v, "wrap_pre");
      v = mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 32'h66, 32'h0, 32'h0, 32'h0);
      cycle(v, "wrap_post");

      // Randomized cycles, with expected values taken from the reference model
      for (int n = 0; n < 400; n++) begin
         v.rst = ($urandom_range(0, 24) != 0);
         v.we  = $urandom_range(0, 1);
         v.mtr = $urandom_range(0, 1);
         v.alu = $urandom;
         v.mem = $urandom;
         v.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         v.rs1 = ($urandom_range(0, 2) == 0) ? v.rd : 5'($urandom_range(0, 31));
         v.rs2 = ($urandom_range(0, 2) == 0) ? v.rd : 5'($urandom_range(0, 31));
         v.e_wb  = v.mtr ? v.mem : v.alu;
         v.e_rs1 = m_read(v.rs1, v.rst, v.we, v.rd, v.e_wb);
         v.e_rs2 = m_read(v.rs2, v.rst, v.we, v.rd, v.e_wb);
         v.e_cnt = m_cnt;
         cycle(v, $sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
